find_bkt_lvl: RTL and testbench

- Reader of the lvls-states RAM written during decision and backtrack.
- On a conflict that cannot be resolved inside the current bin, scans decision levels downward from the current level.
- Finds the highest level whose decision has not yet been flipped.
- Reports that level and the bin that owns its decision. The level feeds the bin manager's backtrack-across-bins step as its backtrack level; if no such level exists, reports global UNSAT.

---
 rtl/find_bkt_lvl.sv | 165 ++++++++++++++++
 tb/tb_find_bkt_lvl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/find_bkt_lvl.sv
// Backtrack-level finder: scans the lvls-states RAM downward from the current
// level and reports the highest level whose decision has not yet been flipped.
module find_bkt_lvl #(
    parameter int unsigned WIDTH_LVL              = 16,
    parameter int unsigned WIDTH_BIN              = 9,
    parameter int unsigned WIDTH_LVL_STATES       = 30,
    parameter int unsigned ADDR_WIDTH_LVLS_STATES = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_find,
    input  logic [WIDTH_LVL-1:0]              cur_lvl_i,
    output logic                              done_find,
    output logic                              unsat_o,
    output logic [WIDTH_LVL-1:0]              bkt_lvl_o,
    output logic [WIDTH_BIN-1:0]              bkt_bin_o,
    output logic                              rd_busy_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_raddr_ls_o,
    input  logic [WIDTH_LVL_STATES-1:0]       ram_rdata_ls_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                            state_q,   state_d;
    logic [WIDTH_LVL-1:0]              lvl_cnt_q, lvl_cnt_d;
    logic                              iss_vld_q, iss_vld_d;
    logic [WIDTH_LVL-1:0]              iss_tag_q, iss_tag_d;
    logic                              chk_vld_q, chk_vld_d;
    logic [WIDTH_LVL-1:0]              chk_tag_q, chk_tag_d;
    logic                              done_q,    done_d;
    logic                              unsat_q,   unsat_d;
    logic [WIDTH_LVL-1:0]              bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN-1:0]              bkt_bin_q, bkt_bin_d;
    logic                              busy_q,    busy_d;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] raddr_q,   raddr_d;

    logic                 flipped_c;
    logic [WIDTH_BIN-1:0] dcd_bin_c;
    logic                 unused_rdata;

    // RAM word: bit0 flipped flag, next WIDTH_BIN bits the owning bin.
    assign flipped_c    = ram_rdata_ls_i[0];
    assign dcd_bin_c    = ram_rdata_ls_i[WIDTH_BIN:1];
    assign unused_rdata = ^ram_rdata_ls_i[WIDTH_LVL_STATES-1:WIDTH_BIN+1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            lvl_cnt_q <= '0;
            iss_vld_q <= 1'b0;
            iss_tag_q <= '0;
            chk_vld_q <= 1'b0;
            chk_tag_q <= '0;
            done_q    <= 1'b0;
            unsat_q   <= 1'b0;
            bkt_lvl_q <= '0;
            bkt_bin_q <= '0;
            busy_q    <= 1'b0;
            raddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            lvl_cnt_q <= lvl_cnt_d;
            iss_vld_q <= iss_vld_d;
            iss_tag_q <= iss_tag_d;
            chk_vld_q <= chk_vld_d;
            chk_tag_q <= chk_tag_d;
            done_q    <= done_d;
            unsat_q   <= unsat_d;
            bkt_lvl_q <= bkt_lvl_d;
            bkt_bin_q <= bkt_bin_d;
            busy_q    <= busy_d;
            raddr_q   <= raddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lvl_cnt_d = lvl_cnt_q;
        iss_vld_d = 1'b0;
        iss_tag_d = iss_tag_q;
        chk_vld_d = iss_vld_q;
        chk_tag_d = iss_tag_q;
        done_d    = 1'b0;
        unsat_d   = unsat_q;
        bkt_lvl_d = bkt_lvl_q;
        bkt_bin_d = bkt_bin_q;
        busy_d    = busy_q;
        raddr_d   = raddr_q;

        unique case (state_q)
            IDLE: begin
                raddr_d   = '0;
                chk_vld_d = 1'b0;
                if (start_find) begin
                    unsat_d   = 1'b0;
                    bkt_lvl_d = '0;
                    bkt_bin_d = '0;
                    if (cur_lvl_i == '0) begin
                        // Already at the root: nothing left to flip.
                        state_d = DONE;
                        done_d  = 1'b1;
                        unsat_d = 1'b1;
                    end else begin
                        state_d   = SCAN;
                        lvl_cnt_d = cur_lvl_i;
                        busy_d    = 1'b1;
                    end
                end
            end

            SCAN: begin
                // Issue side keeps reading downward until level 1 has been issued.
                if (lvl_cnt_q != '0) begin
                    raddr_d   = ADDR_WIDTH_LVLS_STATES'(lvl_cnt_q);
                    lvl_cnt_d = lvl_cnt_q - WIDTH_LVL'(1);
                    iss_vld_d = 1'b1;
                    iss_tag_d = lvl_cnt_q;
                end
                // Check side wins over any read issued in the same cycle.
                if (chk_vld_q && (!flipped_c || (chk_tag_q == WIDTH_LVL'(1)))) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    raddr_d   = '0;
                    lvl_cnt_d = '0;
                    iss_vld_d = 1'b0;
                    chk_vld_d = 1'b0;
                    if (!flipped_c) begin
                        unsat_d   = 1'b0;
                        bkt_lvl_d = chk_tag_q;
                        bkt_bin_d = dcd_bin_c;
                    end else begin
                        unsat_d   = 1'b1;
                        bkt_lvl_d = '0;
                        bkt_bin_d = '0;
                    end
                end
            end

            DONE: begin
                state_d   = IDLE;
                raddr_d   = '0;
                chk_vld_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
                raddr_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign done_find      = done_q;
    assign unsat_o        = unsat_q;
    assign bkt_lvl_o      = bkt_lvl_q;
    assign bkt_bin_o      = bkt_bin_q;
    assign rd_busy_o      = busy_q;
    assign ram_raddr_ls_o = raddr_q;

endmodule

// File: tb/tb_find_bkt_lvl.sv
// Bench for find_bkt_lvl: a 1-cycle-latency RAM model plus a reference search
// over the level table predicts latency, result and the read-address trace.
module tb_find_bkt_lvl;

    logic        clk;
    logic        rst;
    logic        start_find;
    logic [15:0] cur_lvl_i;
    logic        done_find;
    logic        unsat_o;
    logic [15:0] bkt_lvl_o;
    logic [8:0]  bkt_bin_o;
    logic        rd_busy_o;
    logic [8:0]  ram_raddr_ls_o;
    logic [29:0] ram_rdata_ls_i;

    logic [29:0] mem [0:511];

    int errors;
    int checks;

    int          obs_done;
    logic        obs_u;
    logic [15:0] obs_l;
    logic [8:0]  obs_b;
    logic        obs_busy [0:1023];
    logic [8:0]  obs_addr [0:1023];
    logic        nxt_done;
    logic        nxt_u;
    logic [15:0] nxt_l;
    logic [8:0]  nxt_b;
    logic        nxt_busy;
    logic [8:0]  nxt_addr;

    find_bkt_lvl dut (
        .clk            (clk),
        .rst            (rst),
        .start_find     (start_find),
        .cur_lvl_i      (cur_lvl_i),
        .done_find      (done_find),
        .unsat_o        (unsat_o),
        .bkt_lvl_o      (bkt_lvl_o),
        .bkt_bin_o      (bkt_bin_o),
        .rd_busy_o      (rd_busy_o),
        .ram_raddr_ls_o (ram_raddr_ls_o),
        .ram_rdata_ls_i (ram_rdata_ls_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata_ls_i <= mem[ram_raddr_ls_o];

    // Level word with random don't-care upper bits.
    function automatic logic [29:0] word(input int bin, input bit flipped);
        logic [19:0] upper;
        upper = 20'($urandom);
        return {upper, 9'(bin), flipped};
    endfunction

    // Reference: highest unflipped level in [1..c], with its completion cycle.
    function automatic void ref_find(input int c, output int lat, output logic u,
                                     output int l, output int b);
        logic [29:0] w;
        u = 1'b1; l = 0; b = 0;
        lat = (c == 0) ? 1 : c + 3;
        for (int k = c; k >= 1; k--) begin
            w = mem[k];
            if (w[0] == 1'b0) begin
                u = 1'b0; l = k; b = int'(w[9:1]); lat = 4 + c - k;
                break;
            end
        end
    endfunction

    // Address expected on the port in busy cycle n: one level per cycle, held at 1.
    function automatic logic [8:0] exp_addr(input int c, input int n);
        if (n <= 1) return 9'd0;
        if (c - n + 2 >= 1) return 9'(c - n + 2);
        return 9'd1;
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < 512; k++) mem[k] = 30'd0;
    endtask

    // Issue one request; record per-cycle busy/address and the completion cycle.
    task automatic run_find(input int c, input int poke, input int rst_at, input int max_cyc);
        @(negedge clk);
        start_find = 1'b1;
        cur_lvl_i  = 16'(c);
        @(negedge clk);
        start_find = 1'b0;
        cur_lvl_i  = 16'($urandom);
        obs_done   = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            obs_busy[n] = rd_busy_o;
            obs_addr[n] = ram_raddr_ls_o;
            if (done_find) begin
                obs_done = n;
                obs_u = unsat_o; obs_l = bkt_lvl_o; obs_b = bkt_bin_o;
                break;
            end
            start_find = (n == poke);
            if (n == poke) cur_lvl_i = 16'($urandom_range(1, 100));
            rst = (n != rst_at);
            @(negedge clk);
        end
        start_find = 1'b0;
        rst        = 1'b1;
        if (obs_done > 0) begin
            @(negedge clk);
            nxt_done = done_find; nxt_u = unsat_o; nxt_l = bkt_lvl_o; nxt_b = bkt_bin_o;
            nxt_busy = rd_busy_o; nxt_addr = ram_raddr_ls_o;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_find = 1'b0;
        cur_lvl_i = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if ({done_find, unsat_o, bkt_lvl_o, bkt_bin_o, rd_busy_o, ram_raddr_ls_o} !== 37'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got done=%b unsat=%b lvl=%0d bin=%0d busy=%b addr=%0d, expected all 0",
                         n, done_find, unsat_o, bkt_lvl_o, bkt_bin_o, rd_busy_o, ram_raddr_ls_o);
            end
        end
    endtask

    // Scenarios: 0 immediate hit, 1 skip flipped, 2 unsat, 3 root level,
    // 4 start pulse during scan, 5 deepest address with a hit at level 1.
    task automatic test_directed();
        int c, poke, lat, l, b;
        logic u;
        string name;
        for (int s = 0; s < 6; s++) begin
            clear_mem();
            poke = -1;
            case (s)
                0: begin name = "immediate_hit"; c = 5; mem[5] = word(3, 1'b0); end
                1: begin
                    name = "skip_flipped"; c = 6;
                    for (int k = 4; k <= 6; k++) mem[k] = word(k + 20, 1'b1);
                    mem[3] = word(7, 1'b0);
                    mem[2] = word(9, 1'b0);
                end
                2: begin
                    name = "unsat"; c = 4;
                    for (int k = 1; k <= 4; k++) mem[k] = word(k, 1'b1);
                    mem[0] = word(5, 1'b0);
                end
                3: begin name = "root_level"; c = 0; mem[0] = word(4, 1'b0); end
                4: begin
                    name = "start_during_scan"; c = 10; poke = 3;
                    for (int k = 7; k <= 10; k++) mem[k] = word(k, 1'b1);
                    mem[6] = word(9'h1ab, 1'b0);
                end
                default: begin
                    name = "deep_scan"; c = 511;
                    for (int k = 2; k <= 511; k++) mem[k] = word(k & 511, 1'b1);
                    mem[1] = word(9'h155, 1'b0);
                end
            endcase
            ref_find(c, lat, u, l, b);
            run_find(c, poke, -1, lat + 8);
            checks++;
            if (obs_done !== lat) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, obs_done, lat);
            end
            if (obs_done == lat) begin
                checks++;
                if ({obs_u, obs_l, obs_b} !== {u, 16'(l), 9'(b)}) begin
                    errors++;
                    $display("FAIL %s result: got unsat=%b lvl=%0d bin=%0d expected unsat=%b lvl=%0d bin=%0d",
                             name, obs_u, obs_l, obs_b, u, l, b);
                end
                for (int n = 1; n < lat; n++) begin
                    checks++;
                    if (obs_busy[n] !== 1'b1 || obs_addr[n] !== exp_addr(c, n)) begin
                        errors++;
                        $display("FAIL %s scan_cycle %0d: got busy=%b addr=%0d expected busy=1 addr=%0d",
                                 name, n, obs_busy[n], obs_addr[n], exp_addr(c, n));
                    end
                end
                checks++;
                if (obs_busy[lat] !== 1'b0 || obs_addr[lat] !== 9'd0) begin
                    errors++;
                    $display("FAIL %s done_cycle_bus: got busy=%b addr=%0d expected busy=0 addr=0",
                             name, obs_busy[lat], obs_addr[lat]);
                end
                checks++;
                if ({nxt_done, nxt_busy, nxt_addr, nxt_u, nxt_l, nxt_b} !== {1'b0, 1'b0, 9'd0, u, 16'(l), 9'(b)}) begin
                    errors++;
                    $display("FAIL %s after_done: got done=%b busy=%b addr=%0d unsat=%b lvl=%0d bin=%0d expected done=0 busy=0 addr=0 unsat=%b lvl=%0d bin=%0d",
                             name, nxt_done, nxt_busy, nxt_addr, nxt_u, nxt_l, nxt_b, u, l, b);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, l, b;
        logic u;
        clear_mem();
        for (int k = 7; k <= 8; k++) mem[k] = word(k, 1'b1);
        mem[6] = word(12, 1'b0);
        run_find(8, -1, 3, 20);
        checks++;
        if (obs_done !== -1) begin
            errors++;
            $display("FAIL reset_mid_scan no_done: got done in cycle %0d expected none", obs_done);
        end
        checks++;
        if ({done_find, unsat_o, bkt_lvl_o, bkt_bin_o, rd_busy_o, ram_raddr_ls_o} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid_scan outputs: got done=%b unsat=%b lvl=%0d bin=%0d busy=%b addr=%0d expected all 0",
                     done_find, unsat_o, bkt_lvl_o, bkt_bin_o, rd_busy_o, ram_raddr_ls_o);
        end
        mem[2] = word(33, 1'b0);
        ref_find(2, lat, u, l, b);
        run_find(2, -1, -1, 12);
        checks++;
        if (obs_done !== lat || {obs_u, obs_l, obs_b} !== {u, 16'(l), 9'(b)}) begin
            errors++;
            $display("FAIL reset_mid_scan restart: got cycle=%0d unsat=%b lvl=%0d bin=%0d expected cycle=%0d unsat=%b lvl=%0d bin=%0d",
                     obs_done, obs_u, obs_l, obs_b, lat, u, l, b);
        end
    endtask

    task automatic test_random();
        int c, lat, l, b;
        logic u;
        bit all_flipped;
        for (int it = 0; it < 30; it++) begin
            clear_mem();
            c = $urandom_range(0, 40);
            all_flipped = ($urandom_range(0, 4) == 0);
            for (int k = 0; k <= 40; k++)
                mem[k] = word($urandom_range(0, 511), all_flipped || ($urandom_range(0, 3) != 0));
            ref_find(c, lat, u, l, b);
            run_find(c, -1, -1, lat + 8);
            checks++;
            if (obs_done !== lat) begin
                errors++;
                $display("FAIL random_%0d done_cycle: cur=%0d got %0d expected %0d", it, c, obs_done, lat);
            end
            if (obs_done == lat) begin
                checks++;
                if ({obs_u, obs_l, obs_b} !== {u, 16'(l), 9'(b)}) begin
                    errors++;
                    $display("FAIL random_%0d result: cur=%0d got unsat=%b lvl=%0d bin=%0d expected unsat=%b lvl=%0d bin=%0d",
                             it, c, obs_u, obs_l, obs_b, u, l, b);
                end
                for (int n = 1; n < lat; n++) begin
                    checks++;
                    if (obs_busy[n] !== 1'b1 || obs_addr[n] !== exp_addr(c, n)) begin
                        errors++;
                        $display("FAIL random_%0d scan_cycle %0d: got busy=%b addr=%0d expected busy=1 addr=%0d",
                                 it, n, obs_busy[n], obs_addr[n], exp_addr(c, n));
                    end
                end
                checks++;
                if ({nxt_done, nxt_busy, nxt_addr, nxt_u, nxt_l, nxt_b} !== {1'b0, 1'b0, 9'd0, u, 16'(l), 9'(b)}) begin
                    errors++;
                    $display("FAIL random_%0d after_done: got done=%b busy=%b addr=%0d unsat=%b lvl=%0d bin=%0d expected done=0 busy=0 addr=0 unsat=%b lvl=%0d bin=%0d",
                             it, nxt_done, nxt_busy, nxt_addr, nxt_u, nxt_l, nxt_b, u, l, b);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        start_find = 1'b0;
        cur_lvl_i = 16'd0;
        clear_mem();
        test_reset();
        test_directed();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
